// File: rtl/pdm_if.sv
`timescale 1ns/1ps
// Bundles the two PDM input streams and the recovered PCM outputs of pdm_stream_decoder.
// The source side (modulator or bench) uses master; the decoder uses slave.
interface pdm_if;
    logic        lft_PDM;
    logic        rght_PDM;
    logic [15:0] lft_inverse;
    logic [15:0] rght_inverse;
    logic        sample_vld;

    modport master (
        output lft_PDM, rght_PDM,
        input  lft_inverse, rght_inverse, sample_vld
    );

    modport slave (
        input  lft_PDM, rght_PDM,
        output lft_inverse, rght_inverse, sample_vld
    );
endinterface

// File: rtl/pdm_stream_decoder.sv
`timescale 1ns/1ps
// Windowed ones-count PDM to 16-bit signed PCM decoder, two independent channels.
// Optional macro PDM_SMOOTH_EN averages the last 4 window results per channel.
module pdm_stream_decoder #(
    parameter int WIN_LOG2 = 10
) (
    input  logic   clk,
    input  logic   rst,
    pdm_if.slave   bus
);
    localparam int SHIFT = 16 - WIN_LOG2;

    logic [WIN_LOG2-1:0] win_cnt_reg;
    logic                last_cycle;
    logic                vld_reg;
    logic [1:0]          pdm_bit;
    logic [15:0]         ch_out [2];

    assign pdm_bit    = {bus.rght_PDM, bus.lft_PDM};
    assign last_cycle = (win_cnt_reg == {WIN_LOG2{1'b1}});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_cnt_reg <= '0;
            vld_reg     <= 1'b0;
        end else begin
            win_cnt_reg <= win_cnt_reg + 1'b1;
            vld_reg     <= last_cycle;
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_chan
            logic [WIN_LOG2:0] ones_reg;
            logic [WIN_LOG2:0] total;
            logic [16:0]       scaled;
            logic [15:0]       sat;
            logic [15:0]       out_reg;
            logic [15:0]       out_next;

            // The bit seen on the window's last cycle belongs to the closing window.
            assign total  = ones_reg + (WIN_LOG2+1)'(pdm_bit[gi]);
            assign scaled = 17'(total) << SHIFT;
            // scaled - 32768 for 0..65535 is just an MSB flip; 65536 is the only saturating case.
            assign sat    = scaled[16] ? 16'h7FFF : {~scaled[15], scaled[14:0]};

`ifdef PDM_SMOOTH_EN
            logic signed [15:0] hist_reg [3];
            logic signed [17:0] sum;
            logic signed [17:0] avg;

            assign sum      = 18'($signed(sat)) + 18'(hist_reg[0])
                            + 18'(hist_reg[1]) + 18'(hist_reg[2]);
            assign avg      = sum >>> 2;
            assign out_next = avg[15:0];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < 3; i++) hist_reg[i] <= '0;
                end else if (last_cycle) begin
                    hist_reg[0] <= $signed(sat);
                    hist_reg[1] <= hist_reg[0];
                    hist_reg[2] <= hist_reg[1];
                end
            end
`else
            assign out_next = sat;
`endif

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    ones_reg <= '0;
                    out_reg  <= '0;
                end else if (last_cycle) begin
                    ones_reg <= '0;
                    out_reg  <= out_next;
                end else begin
                    ones_reg <= total;
                end
            end

            assign ch_out[gi] = out_reg;
        end
    endgenerate

    assign bus.lft_inverse  = ch_out[0];
    assign bus.rght_inverse = ch_out[1];
    assign bus.sample_vld   = vld_reg;
endmodule

// File: tb/tb_pdm_stream_decoder.sv
`timescale 1ns/1ps
// Self-checking bench for pdm_stream_decoder: per-cycle comparison against a window-count
// model, plus literal checks of the headline duty-cycle mappings and reset behaviour.
module tb_pdm_stream_decoder;
    localparam int W   = 10;
    localparam int WIN = 1 << W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    pdm_if pdm ();

    pdm_stream_decoder #(.WIN_LOG2(W)) dut (.clk(clk), .rst(rst), .bus(pdm));

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: position in window, ones seen so far, expected outputs.
    int pos, cnt_l, cnt_r, exp_l, exp_r, exp_v;
    int hl [3];
    int hr [3];

    function automatic int window_value(input int total);
        int v;
        v = total * (1 << (16 - W)) - 32768;
        if (v > 32767) v = 32767;
        return v;
    endfunction

    function automatic int avg4(input int a, input int b, input int c, input int d);
        int s;
        s = a + b + c + d;
        return s >>> 2;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pos = 0; cnt_l = 0; cnt_r = 0; exp_l = 0; exp_r = 0; exp_v = 0;
            for (int i = 0; i < 3; i++) begin hl[i] = 0; hr[i] = 0; end
        end else begin
            int vl, vr;
            exp_v = 0;
            cnt_l += int'(pdm.lft_PDM);
            cnt_r += int'(pdm.rght_PDM);
            pos++;
            if (pos == WIN) begin
                vl = window_value(cnt_l);
                vr = window_value(cnt_r);
`ifdef PDM_SMOOTH_EN
                exp_l = avg4(vl, hl[0], hl[1], hl[2]);
                exp_r = avg4(vr, hr[0], hr[1], hr[2]);
                hl[2] = hl[1]; hl[1] = hl[0]; hl[0] = vl;
                hr[2] = hr[1]; hr[1] = hr[0]; hr[0] = vr;
`else
                exp_l = vl;
                exp_r = vr;
`endif
                exp_v = 1;
                pos = 0; cnt_l = 0; cnt_r = 0;
            end
        end
    end

    // Compare process and sample watcher, sampled 2 ns after each rising edge.
    int cyc = 0, vld_cnt = 0, last_vld_cyc = 0;
    logic [15:0] last_l = '0, last_r = '0;

    always @(posedge clk) begin
        #2;
        check("lft_inverse", 32'($signed(pdm.lft_inverse)), 32'(exp_l));
        check("rght_inverse", 32'($signed(pdm.rght_inverse)), 32'(exp_r));
        check("sample_vld", 32'(pdm.sample_vld), 32'(exp_v));
        if (rst) cyc = 0;
        else cyc++;
        if (pdm.sample_vld) begin
            vld_cnt++;
            last_vld_cyc = cyc;
            last_l = pdm.lft_inverse;
            last_r = pdm.rght_inverse;
        end
    end

    // Patterns: 0 const 0, 1 const 1, 2 alternating 1,0, 3 repeating 1,1,1,0, 4 half-window ones.
    function automatic logic pat_bit(input int p, input int i);
        case (p)
            0:       return 1'b0;
            1:       return 1'b1;
            2:       return (i % 2) == 0;
            3:       return (i % 4) != 3;
            4:       return (i % WIN) < (WIN / 2);
            default: return 1'b0;
        endcase
    endfunction

    task automatic drive(input int n, input int lp, input int rp);
        for (int i = 0; i < n; i++) begin
            pdm.lft_PDM  = pat_bit(lp, i);
            pdm.rght_PDM = pat_bit(rp, i);
            @(negedge clk);
        end
    endtask

    initial begin
        int saved;
        pdm.lft_PDM  = 1'b0;
        pdm.rght_PDM = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_lft", 32'(pdm.lft_inverse), 32'h0);
        check("reset_rght", 32'(pdm.rght_inverse), 32'h0);
        check("reset_vld", 32'(pdm.sample_vld), 32'h0);

        rst = 1'b0;
        drive(WIN, 0, 0);
        check("first_vld_cycle", 32'(last_vld_cyc), 32'd1024);
        check("first_vld_count", 32'(vld_cnt), 32'd1);
`ifndef PDM_SMOOTH_EN
        check("zero_lft", 32'(last_l), 32'h8000);
        check("zero_rght", 32'(last_r), 32'h8000);
`endif

        drive(2 * WIN, 1, 1);
        check("ones_vld_count", 32'(vld_cnt), 32'd3);
        check("ones_vld_cycle", 32'(last_vld_cyc), 32'd3072);
`ifndef PDM_SMOOTH_EN
        check("ones_lft_sat", 32'(last_l), 32'h7FFF);
        check("ones_rght_sat", 32'(last_r), 32'h7FFF);
`endif

        drive(2 * WIN, 2, 3);
`ifndef PDM_SMOOTH_EN
        check("half_duty_lft", 32'(last_l), 32'h0000);
        check("3q_duty_rght", 32'(last_r), 32'h4000);
`endif

        drive(WIN, 4, 0);
`ifndef PDM_SMOOTH_EN
        check("half_window_lft", 32'(last_l), 32'h0000);
`endif
        drive(WIN, 0, 0);
`ifndef PDM_SMOOTH_EN
        check("after_half_lft", 32'(last_l), 32'h8000);
`endif

        drive(WIN + 500, 1, 1);
        rst = 1'b1;
        #1;
        check("midreset_lft", 32'(pdm.lft_inverse), 32'h0);
        check("midreset_rght", 32'(pdm.rght_inverse), 32'h0);
        check("midreset_vld", 32'(pdm.sample_vld), 32'h0);
        @(negedge clk);
        drive(2, 1, 1);
        rst = 1'b0;
        saved = vld_cnt;
        drive(WIN - 1, 0, 0);
        check("no_early_vld", 32'(vld_cnt), 32'(saved));
        drive(1, 0, 0);
        check("post_reset_vld", 32'(vld_cnt), 32'(saved + 1));
        check("post_reset_cycle", 32'(last_vld_cyc), 32'd1024);
`ifndef PDM_SMOOTH_EN
        check("post_reset_lft", 32'(last_l), 32'h8000);
`endif

        drive(WIN, 1, 1);
`ifndef PDM_SMOOTH_EN
        check("step_lft", 32'(last_l), 32'h7FFF);
        check("step_rght", 32'(last_r), 32'h7FFF);
`endif
        drive(3 * WIN, 1, 0);
        drive(4, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
